mem_access_unit: RTL and testbench

- MEM-stage load/store controller in the 5-stage MIPS pipeline.
- Sits between the EX/MEM pipeline register and MEMWBControlCarrier.
- Turns MemRead/MemWrite of the instruction in M into a req/ack data-bus transaction with byte enables and store-lane replication, and raises StallM while the access is outstanding.
- Flags misaligned addresses, drives the memory/device select, and returns the raw read word for the WB stage to extract and extend.

---
 rtl/mips_mem_pkg.sv | 24 ++
 rtl/mem_lane_gen.sv | 41 ++++
 rtl/mem_access_unit.sv | 178 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// ============================================================================
// Module  : mips_mem_pkg
// Brief   : Shared memory-type codes, MEM-stage FSM states and the device base.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mips_mem_pkg;

    localparam logic [1:0] MT_WORD = 2'b00;
    localparam logic [1:0] MT_HALF = 2'b01;
    localparam logic [1:0] MT_BYTE = 2'b10;

    localparam logic [31:0] DEV_BASE_DEFAULT = 32'h0000_7F00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/mem_lane_gen.sv
// ============================================================================
// Module  : mem_lane_gen
// Brief   : Byte enables, lane-replicated store data and misalignment check.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_lane_gen
    import mips_mem_pkg::*;
(
    input  logic [1:0]  mem_type_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic        misaligned_o
);

    always_comb begin
        be_o         = 4'b1111;
        wdata_o      = wdata_i;
        misaligned_o = (addr_lo_i != 2'b00);
        case (mem_type_i)
            MT_HALF: begin
                be_o         = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o      = {2{wdata_i[15:0]}};
                misaligned_o = addr_lo_i[0];
            end
            MT_BYTE: begin
                be_o         = 4'b0001 << addr_lo_i;
                wdata_o      = {4{wdata_i[7:0]}};
                misaligned_o = 1'b0;
            end
            // MT_WORD and the unused 2'b11 code both behave as a word access
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module  : mem_access_unit
// Brief   : MEM-stage load/store bus controller; optional bus timeout is
//           enabled with `define MEM_BUS_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_access_unit
    import mips_mem_pkg::*;
#(
    parameter logic [31:0] DEV_BASE       = DEV_BASE_DEFAULT,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        InterruptRequest,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [1:0]  MemTypeM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    output logic        MemorySelectM,
    output logic        StallM,
    output logic [31:0] ReadDataM,
    output logic        AddrErrLoadM,
    output logic        AddrErrStoreM,
    output logic        BusErrM
);

    state_e      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;

    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic        misaligned;
    logic        launch;

`ifdef MEM_BUS_TIMEOUT_EN
    logic [7:0]  cnt_q, cnt_d;
    logic        buserr_q, buserr_d;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

    mem_lane_gen u_lane_gen (
        .mem_type_i   (MemTypeM),
        .addr_lo_i    (ALUOutM[1:0]),
        .wdata_i      (WriteDataM),
        .be_o         (lane_be),
        .wdata_o      (lane_wdata),
        .misaligned_o (misaligned)
    );

    assign launch        = (MemReadM | MemWriteM) & ~misaligned & ~InterruptRequest;
    assign AddrErrLoadM  = MemReadM & misaligned;
    assign AddrErrStoreM = MemWriteM & misaligned;
    assign MemorySelectM = (ALUOutM >= DEV_BASE);

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        StallM   = 1'b0;
`ifdef MEM_BUS_TIMEOUT_EN
        cnt_d    = cnt_q;
        buserr_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                StallM = launch;
                if (launch) begin
                    state_d = ST_BUSY;
                    req_d   = 1'b1;
                    we_d    = MemWriteM;
                    addr_d  = {ALUOutM[31:2], 2'b00};
                    be_d    = lane_be;
                    wdata_d = lane_wdata;
`ifdef MEM_BUS_TIMEOUT_EN
                    cnt_d   = 8'd0;
`endif
                end
            end
            ST_BUSY: begin
                StallM = 1'b1;
                if (mem_ack) begin
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = ST_DONE;
                end else if (InterruptRequest && !we_q) begin
                    // Loads can be abandoned; stores always complete to avoid partial writes
                    req_d   = 1'b0;
                    state_d = ST_IDLE;
                end
`ifdef MEM_BUS_TIMEOUT_EN
                else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
                    req_d    = 1'b0;
                    we_d     = 1'b0;
                    rdata_d  = 32'd0;
                    buserr_d = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 32'd0;
            be_q     <= 4'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
`ifdef MEM_BUS_TIMEOUT_EN
            cnt_q    <= 8'd0;
            buserr_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
`ifdef MEM_BUS_TIMEOUT_EN
            cnt_q    <= cnt_d;
            buserr_q <= buserr_d;
`endif
        end
    end

    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;
    assign ReadDataM = rdata_q;
`ifdef MEM_BUS_TIMEOUT_EN
    assign BusErrM   = buserr_q;
`else
    assign BusErrM   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// Module  : tb_mem_access_unit
// Brief   : Randomized self-checking bench for mem_access_unit against a
//           transaction-level model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        InterruptRequest;
    logic        MemReadM, MemWriteM;
    logic [1:0]  MemTypeM;
    logic [31:0] ALUOutM, WriteDataM;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        MemorySelectM, StallM;
    logic [31:0] ReadDataM;
    logic        AddrErrLoadM, AddrErrStoreM, BusErrM;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_rdata = 32'd0;

    always #5 clk = ~clk;

    mem_access_unit #(
        .DEV_BASE       (32'h0000_7F00),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .InterruptRequest (InterruptRequest),
        .MemReadM         (MemReadM),
        .MemWriteM        (MemWriteM),
        .MemTypeM         (MemTypeM),
        .ALUOutM          (ALUOutM),
        .WriteDataM       (WriteDataM),
        .mem_ack          (mem_ack),
        .mem_rdata        (mem_rdata),
        .mem_req          (mem_req),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_be           (mem_be),
        .mem_wdata        (mem_wdata),
        .MemorySelectM    (MemorySelectM),
        .StallM           (StallM),
        .ReadDataM        (ReadDataM),
        .AddrErrLoadM     (AddrErrLoadM),
        .AddrErrStoreM    (AddrErrStoreM),
        .BusErrM          (BusErrM)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] m_be(input logic [1:0] t, input logic [31:0] a);
        int off = int'(a % 4);
        case (t)
            2'b01:   return 4'(3 << ((off / 2) * 2));
            2'b10:   return 4'(1 << off);
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] t, input logic [31:0] d);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            case (t)
                2'b01:   r[8*i +: 8] = d[8*(i%2) +: 8];
                2'b10:   r[8*i +: 8] = d[7:0];
                default: r[8*i +: 8] = d[8*i +: 8];
            endcase
        end
        return r;
    endfunction

    function automatic bit m_mis(input logic [1:0] t, input logic [31:0] a);
        case (t)
            2'b01:   return (a % 2) != 0;
            2'b10:   return 1'b0;
            default: return (a % 4) != 0;
        endcase
    endfunction

    task automatic drive_idle();
        MemReadM = 0; MemWriteM = 0; MemTypeM = 0; ALUOutM = 0; WriteDataM = 0;
        InterruptRequest = 0; mem_ack = 0; mem_rdata = 0;
    endtask

    task automatic to_drive();
        @(posedge clk); #1;
    endtask

    // One MEM-stage instruction. irq_at: -1 none, -2 flush in IDLE, k>=0 flush in BUSY cycle k.
    // Starts and ends just after a rising edge with the unit idle.
    task automatic run_access(input bit rd, input bit wr, input logic [1:0] t,
                              input logic [31:0] a, input logic [31:0] d,
                              input int waits, input int irq_at);
        bit mis, go, flushed;
        logic [31:0] ack_data;
        mis = m_mis(t, a);
        go  = (rd | wr) && !mis && (irq_at != -2);
        flushed = 0;
        ack_data = 32'd0;
        MemReadM = rd; MemWriteM = wr; MemTypeM = t; ALUOutM = a; WriteDataM = d;
        InterruptRequest = (irq_at == -2);
        mem_ack = 1'($urandom % 2);
        mem_rdata = $urandom;
        @(negedge clk);
        chk("idle_stall", 32'(StallM), 32'(go));
        chk("addr_err_load", 32'(AddrErrLoadM), 32'(rd & mis));
        chk("addr_err_store", 32'(AddrErrStoreM), 32'(wr & mis));
        chk("mem_select", 32'(MemorySelectM), 32'(a >= 32'h0000_7F00));
        chk("idle_req", 32'(mem_req), 32'd0);
        if (!go) begin
            to_drive();
            drive_idle();
            @(negedge clk);
            chk("no_launch_req", 32'(mem_req), 32'd0);
            chk("no_launch_rdata", ReadDataM, exp_rdata);
            to_drive();
            return;
        end
        for (int k = 0; k <= waits; k++) begin
            to_drive();
            mem_ack = (k == waits);
            mem_rdata = $urandom;
            InterruptRequest = (k == irq_at);
            if (k == waits) ack_data = mem_rdata;
            @(negedge clk);
            chk("busy_req", 32'(mem_req), 32'd1);
            chk("busy_we", 32'(mem_we), 32'(wr));
            chk("busy_addr", mem_addr, {a[31:2], 2'b00});
            chk("busy_be", 32'(mem_be), 32'(m_be(t, a)));
            if (wr) chk("busy_wdata", mem_wdata, m_wdata(t, d));
            chk("busy_buserr", 32'(BusErrM), 32'd0);
            if (rd && k == irq_at) begin
                flushed = 1;
                break;
            end
            chk("busy_stall", 32'(StallM), 32'd1);
        end
        if (flushed) begin
            to_drive();
            drive_idle();
            @(negedge clk);
            chk("flush_req", 32'(mem_req), 32'd0);
            chk("flush_stall", 32'(StallM), 32'd0);
            chk("flush_rdata", ReadDataM, exp_rdata);
            to_drive();
            return;
        end
        if (rd) exp_rdata = ack_data;
        to_drive();
        mem_ack = 1'($urandom % 2);
        mem_rdata = $urandom;
        InterruptRequest = 0;
        @(negedge clk);
        chk("done_stall", 32'(StallM), 32'd0);
        chk("done_req", 32'(mem_req), 32'd0);
        chk("done_we", 32'(mem_we), 32'd0);
        chk("done_rdata", ReadDataM, exp_rdata);
        chk("done_buserr", 32'(BusErrM), 32'd0);
        to_drive();
        drive_idle();
    endtask

    initial begin
        drive_idle();
        reset = 1'b0;
        #12;
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_be", 32'(mem_be), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_rdata", ReadDataM, 32'd0);
        chk("rst_buserr", 32'(BusErrM), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        to_drive();

        // Directed cases
        run_access(0, 1, 2'b00, 32'h0000_0100, 32'hDEAD_BEEF, 0, -1);
        run_access(0, 1, 2'b10, 32'h0000_0103, 32'h1234_5678, 0, -1);
        run_access(1, 0, 2'b01, 32'h0000_0202, 32'h0, 3, -1);
        chk("lh_rdata_held", ReadDataM, exp_rdata);
        run_access(1, 0, 2'b01, 32'h0000_0201, 32'h0, 0, -1);
        run_access(1, 0, 2'b00, 32'h0000_0300, 32'h0, 3, 1);
        run_access(0, 1, 2'b00, 32'h0000_0304, 32'hCAFE_F00D, 3, 1);
        run_access(1, 0, 2'b00, 32'h0000_8000, 32'h0, 1, -2);
        run_access(0, 1, 2'b11, 32'h0000_7F04, 32'h0BAD_CAFE, 2, -1);

        // Randomized traffic
        for (int n = 0; n < 80; n++) begin
            int op, waits, irq_at, r;
            logic [1:0]  t;
            logic [31:0] a, d;
            bit rd, wr;
            op = int'($urandom % 3);
            rd = (op == 0);
            wr = (op == 1);
            t  = 2'($urandom % 4);
            a  = $urandom;
            if ($urandom % 2) a[31:16] = 16'h0;
            if ($urandom % 2) a[1:0] = 2'b00;
            d  = $urandom;
            waits = int'($urandom % 4);
            irq_at = -1;
            r = int'($urandom % 8);
            if (r == 0) irq_at = -2;
            else if (r == 1) begin
                if (wr) irq_at = int'($urandom_range(0, waits));
                else if (rd && waits > 0) irq_at = int'($urandom_range(0, waits - 1));
            end
            run_access(rd, wr, t, a, d, waits, irq_at);
        end

`ifdef MEM_BUS_TIMEOUT_EN
        // Load with no ack: bus gives up after 4 BUSY cycles
        MemReadM = 1; MemTypeM = 2'b00; ALUOutM = 32'h0000_0400;
        for (int k = 0; k < 4; k++) begin
            to_drive();
            @(negedge clk);
            chk("tmo_busy_req", 32'(mem_req), 32'd1);
        end
        to_drive();
        @(negedge clk);
        chk("tmo_req", 32'(mem_req), 32'd0);
        chk("tmo_buserr", 32'(BusErrM), 32'd1);
        chk("tmo_rdata", ReadDataM, 32'd0);
        chk("tmo_stall", 32'(StallM), 32'd0);
        exp_rdata = 32'd0;
        to_drive();
        drive_idle();
        @(negedge clk);
        chk("tmo_buserr_pulse", 32'(BusErrM), 32'd0);
        to_drive();
        // Ack on the final permitted cycle beats the timeout
        run_access(1, 0, 2'b00, 32'h0000_0408, 32'h0, 3, -1);
`endif

        // Asynchronous reset in the middle of a transaction
        MemWriteM = 1; MemTypeM = 2'b00; ALUOutM = 32'h0000_0500; WriteDataM = 32'h5555_AAAA;
        to_drive();
        @(negedge clk);
        chk("pre_rst_req", 32'(mem_req), 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("async_rst_req", 32'(mem_req), 32'd0);
        chk("async_rst_we", 32'(mem_we), 32'd0);
        chk("async_rst_be", 32'(mem_be), 32'd0);
        chk("async_rst_wdata", mem_wdata, 32'd0);
        chk("async_rst_rdata", ReadDataM, 32'd0);
        chk("async_rst_buserr", 32'(BusErrM), 32'd0);
        drive_idle();
        exp_rdata = 32'd0;
        to_drive();
        reset = 1'b1;
        run_access(1, 0, 2'b10, 32'h0000_0601, 32'h0, 2, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
